// File: rtl/spi_pkg.sv
// Shared definitions for the PCLK-synchronous SPI slave: FSM states, MODE field
// positions and the bit-counter width helper.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;

  // The counter only ever holds 0..n-1; completion is detected at n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input, with rise/fall detection on the
// last synchronised stage against its one-cycle-delayed copy.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // NOTE: the chain is deliberately not reset; it refills within STAGES cycles and an
  // unreset chain cannot fabricate an edge at reset release.
  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[STAGES-2:0], d_i};
    last_q <= sync_q[STAGES-1];
  end

  assign rise_o =  sync_q[STAGES-1] & ~last_q;
  assign fall_o = ~sync_q[STAGES-1] &  last_q;

endmodule

// File: rtl/spi_slave_sync.sv
// Fully synchronous SPI slave: SCK/SS/MOSI oversampled on PCLK, all four modes,
// multi-word frames and a TX holding register with valid/ready handshake.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  SCK,
  input  logic                  SS,
  input  logic                  MOSI,
  input  logic [1:0]            MODE,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_VALID,
  output logic                  TX_READY,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  MISO,
  output logic                  MISO_OE,
  output logic                  UNDERRUN,
  output logic                  FRAME_ERR
);

  localparam int CW = cnt_width(DATA_WIDTH);
  typedef logic [DATA_WIDTH-1:0] word_t;

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  state_e        state_q;
  logic [1:0]    mode_q;
  word_t         tx_sh_q, rx_sh_q, hold_q, rx_data_q;
  logic          hold_full_q, rx_valid_q, oe_q, underrun_q, frame_err_q, urun_pend_q;
  logic [CW-1:0] bit_cnt_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk_i (PCLK),
    .d_i   (SCK),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk_i (PCLK),
    .d_i   (SS),
    .rise_o(ss_rise),
    .fall_o(ss_fall)
  );

  always_ff @(posedge PCLK) begin
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  logic cpol, cpha, lead_edge, trail_edge, sample_edge, shift_edge;
  assign cpol        = mode_q[MODE_CPOL];
  assign cpha        = mode_q[MODE_CPHA];
  assign lead_edge   = cpol ? sck_fall : sck_rise;
  assign trail_edge  = cpol ? sck_rise : sck_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  logic  accept, word_done, load_urun_d;
  word_t rx_next_d, tx_adv_d, load_d;

  assign accept    = TX_VALID & ~hold_full_q;
  assign word_done = sample_edge && (bit_cnt_q == CW'(DATA_WIDTH - 1));
  assign rx_next_d = LSB_FIRST ? {mosi_s, rx_sh_q[DATA_WIDTH-1:1]}
                               : {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
  assign tx_adv_d  = LSB_FIRST ? (tx_sh_q >> 1) : (tx_sh_q << 1);

  // An accept into an empty holding register on a load cycle feeds the shifter directly.
  always_comb begin
    load_d      = '0;
    load_urun_d = 1'b0;
    if (hold_full_q)  load_d = hold_q;
    else if (accept)  load_d = TX_DATA;
    else              load_urun_d = 1'b1;
  end

  // NOTE: reset is synchronous here; PRESET is sampled like any other input.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      oe_q        <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      urun_pend_q <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (accept) begin
        hold_q      <= TX_DATA;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q     <= ACTIVE;
            mode_q      <= MODE;
            oe_q        <= 1'b1;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= load_d;
            hold_full_q <= 1'b0;
            underrun_q  <= load_urun_d;
            urun_pend_q <= 1'b0;
          end
        end

        ACTIVE: begin
          if (ss_rise) begin
            state_q     <= IDLE;
            oe_q        <= 1'b0;
            tx_sh_q     <= '0;
            frame_err_q <= (bit_cnt_q != '0);
            bit_cnt_q   <= '0;
            urun_pend_q <= 1'b0;
          end else if (sample_edge) begin
            rx_sh_q <= rx_next_d;
            // A reload underrun is reported only once the next word actually starts.
            if (urun_pend_q) begin
              underrun_q  <= 1'b1;
              urun_pend_q <= 1'b0;
            end
            if (word_done) begin
              rx_data_q   <= rx_next_d;
              rx_valid_q  <= 1'b1;
              bit_cnt_q   <= '0;
              tx_sh_q     <= load_d;
              hold_full_q <= 1'b0;
              urun_pend_q <= load_urun_d;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end else if (shift_edge && bit_cnt_q != '0) begin
            // With count 0 the word's first bit is already presented, so hold it.
            tx_sh_q <= tx_adv_d;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign TX_READY  = ~hold_full_q;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign MISO      = LSB_FIRST ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1];
  assign MISO_OE   = oe_q;
  assign UNDERRUN  = underrun_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: an MSB-first and an LSB-first instance driven by
// a bit-banged SPI master, with received words checked against a scoreboard queue.
module tb_spi_slave_sync;

  localparam int W    = 8;
  localparam int HALF = 8;

  logic         PCLK = 1'b0;
  logic         PRESET, SCK, SS, MOSI;
  logic [1:0]   MODE;
  logic [W-1:0] TX_DATA, RX_DATA;
  logic         TX_VALID, TX_READY, RX_VALID, MISO, MISO_OE, UNDERRUN, FRAME_ERR;

  logic         ss_l, tx_valid_l, tx_ready_l, rx_valid_l, miso_l, miso_oe_l, urun_l, ferr_l;
  logic [W-1:0] tx_data_l, rx_data_l;

  int checks = 0, errors = 0;
  int rxv_cnt = 0, urun_cnt = 0, ferr_cnt = 0, rxvl_cnt = 0, urunl_cnt = 0, ferrl_cnt = 0;
  logic [W-1:0] rxq[$];
  logic [W-1:0] exp_w;

  always #5 PCLK = ~PCLK;

  spi_slave_sync #(.DATA_WIDTH(W), .SYNC_STAGES(2), .LSB_FIRST(1'b0)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .SCK(SCK), .SS(SS), .MOSI(MOSI), .MODE(MODE),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .MISO(MISO), .MISO_OE(MISO_OE),
    .UNDERRUN(UNDERRUN), .FRAME_ERR(FRAME_ERR)
  );

  spi_slave_sync #(.DATA_WIDTH(W), .SYNC_STAGES(2), .LSB_FIRST(1'b1)) dut_lsb (
    .PCLK(PCLK), .PRESET(PRESET), .SCK(SCK), .SS(ss_l), .MOSI(MOSI), .MODE(MODE),
    .TX_DATA(tx_data_l), .TX_VALID(tx_valid_l), .TX_READY(tx_ready_l),
    .RX_DATA(rx_data_l), .RX_VALID(rx_valid_l), .MISO(miso_l), .MISO_OE(miso_oe_l),
    .UNDERRUN(urun_l), .FRAME_ERR(ferr_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every RX_VALID and counts status pulses.
  always @(negedge PCLK) begin
    if (RX_VALID) begin
      rxv_cnt++;
      check("rx_queue_nonempty", rxq.size() > 0, 1);
      if (rxq.size() > 0) begin
        exp_w = rxq.pop_front();
        check("rx_data", RX_DATA, exp_w);
      end
    end
    if (UNDERRUN)   urun_cnt++;
    if (FRAME_ERR)  ferr_cnt++;
    if (rx_valid_l) rxvl_cnt++;
    if (urun_l)     urunl_cnt++;
    if (ferr_l)     ferrl_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic push_tx(input logic [W-1:0] d);
    int n;
    n = 0;
    @(negedge PCLK);
    TX_DATA  = d;
    TX_VALID = 1'b1;
    while (!TX_READY && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    check("tx_ready_timeout", n < 200, 1);
    @(negedge PCLK);
    TX_VALID = 1'b0;
  endtask

  task automatic frame_begin(input bit lsb);
    @(negedge PCLK);
    if (lsb) ss_l = 1'b0;
    else     SS   = 1'b0;
    repeat (HALF) @(negedge PCLK);
  endtask

  task automatic frame_end(input bit lsb);
    repeat (HALF) @(negedge PCLK);
    if (lsb) ss_l = 1'b1;
    else     SS   = 1'b1;
    repeat (2 * HALF) @(negedge PCLK);
  endtask

  task automatic set_idle_mode(input logic [1:0] m);
    @(negedge PCLK);
    MODE = m;
    SCK  = m[1];
    repeat (HALF) @(negedge PCLK);
  endtask

  // Bit-banged master: sends mtx, returns what it sampled on MISO.
  task automatic spi_word(input logic [W-1:0] mtx, input logic [1:0] mode, input int nbits,
                          input bit lsb, output logic [W-1:0] mrx);
    logic cpol, cpha, ma, mb, mo;
    int   idx;
    cpol = mode[1];
    cpha = mode[0];
    mrx  = '0;
    for (int i = 0; i < nbits; i++) begin
      idx  = lsb ? i : W - 1 - i;
      if (cpha) SCK = ~cpol;
      MOSI = mtx[idx];
      repeat (HALF - 3) @(negedge PCLK);
      ma = lsb ? miso_l : MISO;
      repeat (3) @(negedge PCLK);
      mb = lsb ? miso_l : MISO;
      check("miso_stable_pre", ma, mb);
      mrx[idx] = mb;
      SCK = cpha ? cpol : ~cpol;
      repeat (HALF) @(negedge PCLK);
      if (i != W - 1) begin
        mo = lsb ? miso_l : MISO;
        check("miso_stable_post", mo, mb);
      end
      if (!cpha) SCK = cpol;
    end
  endtask

  initial begin
    logic [W-1:0] r, r2;
    int rxv0, urun0, ferr0;

    PRESET = 1'b1; SCK = 1'b0; SS = 1'b1; ss_l = 1'b1; MOSI = 1'b0; MODE = 2'b00;
    TX_DATA = '0; TX_VALID = 1'b0; tx_data_l = '0; tx_valid_l = 1'b0;
    repeat (10) @(negedge PCLK);
    check("rst_tx_ready", TX_READY, 1);
    check("rst_rx_data", RX_DATA, 0);
    check("rst_rx_valid", RX_VALID, 0);
    check("rst_miso", MISO, 0);
    check("rst_miso_oe", MISO_OE, 0);
    check("rst_underrun", UNDERRUN, 0);
    check("rst_frame_err", FRAME_ERR, 0);
    PRESET = 1'b0;
    repeat (5) @(negedge PCLK);

    // Mode 0 single word, TX 0xA5 preloaded, master sends 0x3C.
    rxv0 = rxv_cnt; urun0 = urun_cnt;
    push_tx(8'hA5);
    check("tx_ready_full", TX_READY, 0);
    frame_begin(0);
    check("miso_oe_active", MISO_OE, 1);
    check("tx_ready_after_load", TX_READY, 1);
    rxq.push_back(8'h3C);
    spi_word(8'h3C, 2'b00, W, 0, r);
    check("m0_miso_word", r, 8'hA5);
    frame_end(0);
    check("m0_rx_pulses", rxv_cnt - rxv0, 1);
    check("m0_no_underrun", urun_cnt - urun0, 0);
    check("idle_miso_oe", MISO_OE, 0);
    check("idle_miso", MISO, 0);

    // Modes 1..3: exchange 0x81 (slave) / 0x7E (master); MODE toggled mid-frame.
    for (int m = 1; m < 4; m++) begin
      rxv0 = rxv_cnt;
      set_idle_mode(m[1:0]);
      push_tx(8'h81);
      frame_begin(0);
      MODE = ~m[1:0];
      rxq.push_back(8'h7E);
      spi_word(8'h7E, m[1:0], W, 0, r);
      check("modes_miso_word", r, 8'h81);
      frame_end(0);
      MODE = m[1:0];
      check("modes_rx_pulses", rxv_cnt - rxv0, 1);
    end
    check("modes_no_underrun", urun_cnt - urun0, 0);

    // Two-word frame, second word written through the handshake mid-frame.
    set_idle_mode(2'b00);
    rxv0 = rxv_cnt; urun0 = urun_cnt;
    push_tx(8'h11);
    frame_begin(0);
    push_tx(8'h22);
    rxq.push_back(8'hA1);
    rxq.push_back(8'hB2);
    spi_word(8'hA1, 2'b00, W, 0, r);
    spi_word(8'hB2, 2'b00, W, 0, r2);
    check("two_word_first", r, 8'h11);
    check("two_word_second", r2, 8'h22);
    frame_end(0);
    check("two_word_rx_pulses", rxv_cnt - rxv0, 2);
    check("two_word_no_underrun", urun_cnt - urun0, 0);

    // Empty holding register at frame start.
    rxv0 = rxv_cnt; urun0 = urun_cnt;
    frame_begin(0);
    check("underrun_at_start", urun_cnt - urun0, 1);
    rxq.push_back(8'h96);
    spi_word(8'h96, 2'b00, W, 0, r);
    check("underrun_miso_zero", r, 8'h00);
    frame_end(0);
    check("underrun_single_pulse", urun_cnt - urun0, 1);
    check("underrun_rx_pulses", rxv_cnt - rxv0, 1);

    // SS released after 5 bits: FRAME_ERR, partial word discarded.
    rxv0 = rxv_cnt; ferr0 = ferr_cnt;
    frame_begin(0);
    spi_word(8'hF0, 2'b00, 5, 0, r);
    frame_end(0);
    check("frame_err_pulse", ferr_cnt - ferr0, 1);
    check("frame_err_no_rx", rxv_cnt - rxv0, 0);
    check("frame_err_rx_held", RX_DATA, 8'h96);

    // LSB-first instance: master sends 0x01, slave sends 0x80.
    @(negedge PCLK);
    tx_data_l  = 8'h80;
    tx_valid_l = 1'b1;
    @(negedge PCLK);
    tx_valid_l = 1'b0;
    check("lsb_tx_ready_full", tx_ready_l, 0);
    frame_begin(1);
    check("lsb_miso_oe", miso_oe_l, 1);
    spi_word(8'h01, 2'b00, W, 1, r);
    check("lsb_miso_word", r, 8'h80);
    frame_end(1);
    check("lsb_rx_data", rx_data_l, 8'h01);
    check("lsb_rx_pulses", rxvl_cnt, 1);
    check("lsb_no_underrun", urunl_cnt, 0);
    check("lsb_no_frame_err", ferrl_cnt, 0);

    // Reset mid-frame after 3 bits, then a clean frame.
    rxv0 = rxv_cnt; ferr0 = ferr_cnt; urun0 = urun_cnt;
    push_tx(8'hC3);
    frame_begin(0);
    spi_word(8'hFF, 2'b00, 3, 0, r);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("prst_tx_ready", TX_READY, 1);
    check("prst_rx_data", RX_DATA, 0);
    check("prst_rx_valid", RX_VALID, 0);
    check("prst_miso", MISO, 0);
    check("prst_miso_oe", MISO_OE, 0);
    check("prst_underrun", UNDERRUN, 0);
    check("prst_frame_err", FRAME_ERR, 0);
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (HALF) @(negedge PCLK);
    SS = 1'b1;
    repeat (2 * HALF) @(negedge PCLK);
    check("prst_stays_idle", MISO_OE, 0);
    check("prst_no_frame_err", ferr_cnt - ferr0, 0);
    push_tx(8'hE7);
    frame_begin(0);
    rxq.push_back(8'h5A);
    spi_word(8'h5A, 2'b00, W, 0, r);
    check("prst_next_miso", r, 8'hE7);
    frame_end(0);
    check("prst_next_rx_pulses", rxv_cnt - rxv0, 1);
    check("prst_next_rx_data", RX_DATA, 8'h5A);
    check("prst_no_underrun", urun_cnt - urun0, 0);

    check("scoreboard_drained", rxq.size(), 0);
    check("total_rx_pulses", rxv_cnt, 8);
    check("total_underruns", urun_cnt, 2);
    check("total_frame_errs", ferr_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
Parametrised, fully synchronous SPI slave. SCK, SS and MOSI are oversampled in the PCLK domain. It supports all four CPOL/CPHA modes, a configurable word width and bit order, multi-word frames, and a TX holding register with valid/ready handshake. It replaces the SCK-clocked slave in the peripheral subsystem and hands received words to the APB-side register file on PCLK.

Parameters:
DATA_WIDTH, 8, bits per SPI word (min 2).
SYNC_STAGES, 2, synchroniser flops on SCK/SS/MOSI (min 2).
LSB_FIRST, 0, 1 = shift LSB first on both MOSI and MISO.

Ports:
PCLK  in  1  system clock; only clock in the block.
PRESET  in  1  synchronous, active-high reset.
SCK  in  1  SPI clock, asynchronous to PCLK.
SS  in  1  slave select, active low, asynchronous.
MOSI  in  1  serial data in, asynchronous.
MODE  in  2  {CPOL,CPHA}; latched at frame start.
TX_DATA  in  DATA_WIDTH  word to transmit.
TX_VALID  in  1  TX_DATA is valid.
TX_READY  out  1  TX holding register empty; transfer when VALID&READY.
RX_DATA  out  DATA_WIDTH  last received word; held until next word.
RX_VALID  out  1  one-PCLK pulse when RX_DATA updates.
MISO  out  1  serial data out; 0 when not driving.
MISO_OE  out  1  high while the frame is active (pad tri-state enable).
UNDERRUN  out  1  one-cycle pulse: word started with TX holding empty (zeros sent).
FRAME_ERR  out  1  one-cycle pulse: SS deasserted with 0 < bit count < DATA_WIDTH.

Behaviour:
- Reset (PRESET=1 at a PCLK edge): FSM to IDLE; shift regs, bit count and holding reg cleared. TX_READY=1, RX_DATA=0, RX_VALID=0, MISO=0, MISO_OE=0, UNDERRUN=0, FRAME_ERR=0. Reset mid-frame aborts the frame with no RX_VALID and no FRAME_ERR; the block stays IDLE until the next SS falling edge after reset is released.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the last synchronised stage versus its one-cycle-delayed copy. Requirement: each SCK half-period ≥ SYNC_STAGES+2 PCLK cycles; SS setup to the first SCK edge has the same requirement.
- Leading edge = SCK rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge = the other one.
- FSM IDLE -> ACTIVE on the synchronised SS falling edge:
  - latch MODE;
  - load the TX shift reg from the holding reg (holding empties, TX_READY=1 next cycle), or load zeros and pulse UNDERRUN if empty;
  - clear bit count; MISO_OE=1 on the same cycle.
- ACTIVE:
  - Sample edge: capture synchronised MOSI into the RX shift reg; bit count +1.
  - Shift edge: advance the TX shift reg. The first bit appears on MISO at frame start; MISO changes only on shift edges.
  - CPHA=1: the first leading edge is a shift edge but must not advance the TX shift reg, because the first bit is already presented.
- Word completion, on the sample edge where bit count reaches DATA_WIDTH:
  - RX_DATA <= assembled word; RX_VALID pulses the next cycle; bit count wraps to 0.
  - The TX shift reg reloads from holding (or zeros + UNDERRUN) so the next word's first bit is ready before the next shift/sample edge.
  - Words continue back-to-back while SS stays low.
- ACTIVE -> IDLE on the synchronised SS rising edge: MISO_OE=0, MISO=0. If 0 < bit count < DATA_WIDTH: pulse FRAME_ERR and discard the partial word (RX_DATA unchanged).
- SCK edges while IDLE are ignored. MODE changes while ACTIVE are ignored.
- Handshake: the holding reg accepts on TX_VALID&TX_READY.
  - A load into the shift reg and a new accept in the same cycle are both honoured (holding refilled, TX_READY stays 0).
  - A load at frame or word start in the same cycle as an accept into an empty holding reg: the accepted word is used directly and UNDERRUN is not pulsed.
- Bit order: LSB_FIRST=0 shifts MSB first; LSB_FIRST=1 shifts LSB first. RX_DATA is always presented in natural bit order.

Decomposition:
- Shared package spi_pkg: FSM state enum (IDLE, ACTIVE), MODE field indices (CPOL=1, CPHA=0), and a clog2-based bit counter width function.
- One natural sub-module: spi_sync_edge, an N-stage synchroniser plus rise/fall detect. Instantiate it for SCK and SS, and a plain synchroniser for MOSI.

Test Plan:
- Mode 0, DATA_WIDTH=8, TX 0xA5 preloaded, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RX_DATA=0x3C with one RX_VALID pulse; UNDERRUN never asserted.
- Modes 1, 2, 3 each: exchange 0x81/0x7E -> correct data both ways; MISO is stable across every sample edge.
- Two-word frame (SS held low): TX 0x11 then 0x22 written via the handshake mid-frame -> master receives 0x11,0x22; two RX_VALID pulses; no UNDERRUN.
- Empty holding at SS fall -> UNDERRUN pulse, MISO all zeros, RX still captured correctly.
- SS rises after 5 bits -> FRAME_ERR pulse, RX_VALID absent, RX_DATA unchanged; LSB_FIRST=1 build: send 0x01 -> first MOSI bit 1, RX_DATA=0x01.
- PRESET asserted after 3 bits -> all outputs at reset values next cycle; a following full frame 0x5A completes normally.
